// File: rtl/accel_pkg.sv
// Shared helpers for the accelerator input path: width math, word/sample
// ratio, parameter legality and the pending-accept state encoding.
package accel_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

    function automatic int words_per(input int data_width, input int bit_width);
        return data_width / bit_width;
    endfunction

    function automatic bit params_legal(input int bit_width, input int data_width,
                                        input int buf_bytes);
        return (bit_width > 32'sd0) && ((data_width % bit_width) == 32'sd0) &&
               (buf_bytes >= 32'sd2 * (data_width / bit_width));
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } acc_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Circular sample buffer: pushes one whole memory word (W samples) and pops
// 0..NUM_CHANNEL samples per cycle; depth need not be a power of two.
module sample_fifo
    import accel_pkg::*;
#(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int BUF_BYTES   = 16,
    localparam int W     = words_per(DATA_WIDTH, BIT_WIDTH),
    localparam int PTR_W = (clog2(BUF_BYTES) > 0) ? clog2(BUF_BYTES) : 1,
    localparam int CNT_W = clog2(BUF_BYTES + 1),
    localparam int POP_W = clog2(NUM_CHANNEL + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             push,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [POP_W-1:0]                 pop_n,
    output logic [BIT_WIDTH*NUM_CHANNEL-1:0] rd_data,
    output logic [PTR_W-1:0]                 rd_ptr,
    output logic [PTR_W-1:0]                 wr_ptr,
    output logic [CNT_W-1:0]                 fcnt,
    output logic [CNT_W-1:0]                 fcnt_nxt
);

    logic [BIT_WIDTH-1:0] mem_r [BUF_BYTES];
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [CNT_W-1:0]     fcnt_r;
    logic [PTR_W-1:0]     rd_ptr_nxt_s;
    logic [PTR_W-1:0]     wr_ptr_nxt_s;

    // Offsets never exceed one buffer length, so one conditional subtract wraps
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr, input int offs);
        int sum;
        sum = int'(ptr) + offs;
        if (sum >= BUF_BYTES) begin
            sum = sum - BUF_BYTES;
        end else begin
            sum = sum;
        end
        return PTR_W'(sum);
    endfunction

    // Sample storage: one word lands as W consecutive samples, sample 0 first
    always_ff @(posedge clk) begin
        if (rst && !clear && push) begin
            for (int i = 0; i < W; i++) begin
                mem_r[ptr_add(wr_ptr_r, i)] <= wdata[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    // Next pointers and occupancy; the caller guarantees pop_n <= fcnt and room for W
    always_comb begin
        rd_ptr_nxt_s = ptr_add(rd_ptr_r, int'(pop_n));
        if (push) begin
            wr_ptr_nxt_s = ptr_add(wr_ptr_r, W);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (clear) begin
            fcnt_nxt = {CNT_W{1'b0}};
        end else begin
            fcnt_nxt = fcnt_r + (push ? CNT_W'(W) : {CNT_W{1'b0}}) - CNT_W'(pop_n);
        end
    end

    // Oldest NUM_CHANNEL samples presented in order, oldest in the low lane
    always_comb begin
        rd_data = {(BIT_WIDTH*NUM_CHANNEL){1'b0}};
        for (int c = 0; c < NUM_CHANNEL; c++) begin
            rd_data[c*BIT_WIDTH +: BIT_WIDTH] = mem_r[ptr_add(rd_ptr_r, c)];
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            fcnt_r   <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            fcnt_r   <= fcnt_nxt;
        end
    end

    assign rd_ptr = rd_ptr_r;
    assign wr_ptr = wr_ptr_r;
    assign fcnt   = fcnt_r;

endmodule

// File: rtl/pixel_repacker.sv
// Repacks DATA_WIDTH memory words into pixels of a runtime channel count,
// with ready/valid output, upstream stall margin, end-of-frame flush and overflow flag.
module pixel_repacker
    import accel_pkg::*;
#(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int BUF_BYTES   = 16,
    parameter int STALL_LAT   = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [clog2(NUM_CHANNEL+1)-1:0]     i_num_channel,
    input  logic                                i_clear,
    input  logic                                i_flush,
    input  logic [DATA_WIDTH-1:0]               idat,
    input  logic                                ival,
    output logic                                ostall,
    output logic [BIT_WIDTH*NUM_CHANNEL-1:0]    odat,
    output logic                                oval,
    input  logic                                ordy,
    output logic [clog2(BUF_BYTES+1)-1:0]       o_fill,
    output logic                                o_err_ovf
);

    localparam int W         = words_per(DATA_WIDTH, BIT_WIDTH);
    localparam int NC_W      = clog2(NUM_CHANNEL + 1);
    localparam int CNT_W     = clog2(BUF_BYTES + 1);
    localparam int PTR_W     = (clog2(BUF_BYTES) > 0) ? clog2(BUF_BYTES) : 1;
    localparam int PIX_W     = BIT_WIDTH * NUM_CHANNEL;
    localparam int STALL_THR = BUF_BYTES - W * (STALL_LAT + 1);

    if (!params_legal(BIT_WIDTH, DATA_WIDTH, BUF_BYTES)) begin : g_param_check
        $error("pixel_repacker: DATA_WIDTH must be a multiple of BIT_WIDTH and BUF_BYTES >= 2*W");
    end

    acc_state_e        state_r;
    acc_state_e        state_nxt_s;
    logic [PIX_W-1:0]  odat_r;
    logic              ostall_r;
    logic              err_r;
    logic              flush_pend_r;
    logic              flush_pend_nxt_s;

    logic [NC_W-1:0]   n_eff_s;
    logic [CNT_W-1:0]  fcnt_s;
    logic [CNT_W-1:0]  fcnt_nxt_s;
    logic [CNT_W-1:0]  free_s;
    logic [PIX_W-1:0]  rd_data_s;
    logic [PIX_W-1:0]  pixel_s;
    logic [NC_W-1:0]   pop_n_s;
    logic [PTR_W-1:0]  rd_ptr_unused_s;
    logic [PTR_W-1:0]  wr_ptr_unused_s;
    logic              push_s;
    logic              drop_s;
    logic              slot_s;
    logic              flush_req_s;
    logic              load_full_s;
    logic              load_part_s;
    logic              load_s;

    sample_fifo #(
        .BIT_WIDTH   (BIT_WIDTH),
        .NUM_CHANNEL (NUM_CHANNEL),
        .DATA_WIDTH  (DATA_WIDTH),
        .BUF_BYTES   (BUF_BYTES)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (i_clear),
        .push     (push_s),
        .wdata    (idat),
        .pop_n    (pop_n_s),
        .rd_data  (rd_data_s),
        .rd_ptr   (rd_ptr_unused_s),
        .wr_ptr   (wr_ptr_unused_s),
        .fcnt     (fcnt_s),
        .fcnt_nxt (fcnt_nxt_s)
    );

    // Out-of-range channel counts fall back to the full pixel width
    always_comb begin
        if ((i_num_channel == {NC_W{1'b0}}) || (int'(i_num_channel) > NUM_CHANNEL)) begin
            n_eff_s = NC_W'(NUM_CHANNEL);
        end else begin
            n_eff_s = i_num_channel;
        end
    end

    // Push/drop decision, output-register load and the pixel assembled from the oldest samples
    always_comb begin
        free_s      = CNT_W'(BUF_BYTES) - fcnt_s;
        push_s      = ival && !i_clear && (int'(free_s) >= W);
        drop_s      = ival && !i_clear && (int'(free_s) < W);
        slot_s      = (state_r == ST_IDLE) || ordy;
        flush_req_s = i_flush || flush_pend_r;
        load_full_s = !i_clear && slot_s && (fcnt_s >= CNT_W'(n_eff_s));
        load_part_s = !i_clear && slot_s && !load_full_s && flush_req_s &&
                      (fcnt_s != {CNT_W{1'b0}});
        load_s      = load_full_s || load_part_s;
        if (load_full_s) begin
            pop_n_s = n_eff_s;
        end else if (load_part_s) begin
            pop_n_s = NC_W'(fcnt_s);
        end else begin
            pop_n_s = {NC_W{1'b0}};
        end
        pixel_s = {PIX_W{1'b0}};
        for (int c = 0; c < NUM_CHANNEL; c++) begin
            if (c < int'(pop_n_s)) begin
                pixel_s[c*BIT_WIDTH +: BIT_WIDTH] = rd_data_s[c*BIT_WIDTH +: BIT_WIDTH];
            end else begin
                pixel_s[c*BIT_WIDTH +: BIT_WIDTH] = {BIT_WIDTH{1'b0}};
            end
        end
        // A flush request waits for a load slot and lapses once nothing is left behind
        flush_pend_nxt_s = flush_req_s && !load_part_s && (fcnt_nxt_s != {CNT_W{1'b0}});
    end

    // Pending-accept FSM next state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (ordy && !load_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output register, FSM state, stall and sticky error
    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            state_r      <= ST_IDLE;
            odat_r       <= {PIX_W{1'b0}};
            ostall_r     <= 1'b0;
            err_r        <= 1'b0;
            flush_pend_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            odat_r       <= load_s ? pixel_s : odat_r;
            ostall_r     <= (int'(fcnt_nxt_s) > STALL_THR);
            err_r        <= err_r || drop_s;
            flush_pend_r <= flush_pend_nxt_s;
        end
    end

    assign oval      = (state_r == ST_HOLD);
    assign odat      = odat_r;
    assign ostall    = ostall_r;
    assign o_fill    = fcnt_s;
    assign o_err_ovf = err_r;

endmodule

// File: tb/tb_pixel_repacker.sv
// Self-checking bench for pixel_repacker: queue-based sample model checked every
// cycle, directed scenarios with literal pixel lists, then randomized traffic.
module tb_pixel_repacker;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_num_channel;
    logic        i_clear;
    logic        i_flush;
    logic [31:0] idat;
    logic        ival;
    logic        ostall;
    logic [23:0] odat;
    logic        oval;
    logic        ordy;
    logic [4:0]  o_fill;
    logic        o_err_ovf;

    pixel_repacker dut (
        .clk           (clk),
        .rst           (rst),
        .i_num_channel (i_num_channel),
        .i_clear       (i_clear),
        .i_flush       (i_flush),
        .idat          (idat),
        .ival          (ival),
        .ostall        (ostall),
        .odat          (odat),
        .oval          (oval),
        .ordy          (ordy),
        .o_fill        (o_fill),
        .o_err_ovf     (o_err_ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: buffer is a byte queue, pixel register is a plain value
    byte unsigned m_q[$];
    logic         m_oval;
    logic [23:0]  m_odat;
    logic         m_err;
    logic         m_ostall;
    logic         m_pend;

    always @(posedge clk) begin : model
        int  n;
        int  fc;
        bit  slot;
        bit  freq;
        bit  part;
        if (!rst || i_clear) begin
            m_q.delete();
            m_oval = 1'b0; m_odat = 24'h0; m_err = 1'b0; m_ostall = 1'b0; m_pend = 1'b0;
        end else begin
            n    = (i_num_channel == 2'd0) ? 3 : int'(i_num_channel);
            fc   = m_q.size();
            slot = !m_oval || ordy;
            freq = i_flush || m_pend;
            part = 1'b0;
            if (slot && fc >= n) begin
                m_odat = 24'h0;
                for (int c = 0; c < n; c++) m_odat[c*8 +: 8] = m_q.pop_front();
                m_oval = 1'b1;
            end else if (slot && freq && fc > 0) begin
                m_odat = 24'h0;
                for (int c = 0; c < fc; c++) m_odat[c*8 +: 8] = m_q.pop_front();
                m_oval = 1'b1;
                part   = 1'b1;
            end else if (slot) begin
                m_oval = 1'b0;
            end
            if (ival) begin
                if (16 - fc >= 4) begin
                    for (int i = 0; i < 4; i++) m_q.push_back(idat[i*8 +: 8]);
                end else begin
                    m_err = 1'b1;
                end
            end
            m_pend   = freq && !part && (m_q.size() != 0);
            m_ostall = m_q.size() > 4;
        end
    end

    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("oval", 32'(oval), 32'(m_oval));
            if (m_oval) chk("odat", 32'(odat), 32'(m_odat));
            chk("o_fill", 32'(o_fill), 32'(m_q.size()));
            chk("ostall", 32'(ostall), 32'(m_ostall));
            chk("o_err_ovf", 32'(o_err_ovf), 32'(m_err));
            if (oval && ordy) got_q.push_back(odat);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) cyc();
    endtask

    task automatic send(input logic [31:0] w);
        ival = 1'b1;
        idat = w;
        cyc();
        ival = 1'b0;
    endtask

    task automatic flush_pulse();
        i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
    endtask

    task automatic cmp_pix(input string name);
        chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(name, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [7:0] b(input int k);
        return 8'(k);
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int nw;
        bit saw_stall;
        logic [31:0] w;

        rst = 1'b0; i_num_channel = 2'd3; i_clear = 1'b0; i_flush = 1'b0;
        idat = 32'h0; ival = 1'b0; ordy = 1'b1;
        idle(2);
        rst    = 1'b1;
        chk_en = 1'b1;
        chk("reset_oval", 32'(oval), 32'h0);
        chk("reset_odat", 32'(odat), 32'h0);
        chk("reset_fill", 32'(o_fill), 32'h0);
        chk("reset_ostall", 32'(ostall), 32'h0);
        chk("reset_err", 32'(o_err_ovf), 32'h0);

        // N=3, three back-to-back words
        got_q.delete();
        ival = 1'b1;
        idat = 32'h04030201; cyc();
        idat = 32'h08070605; cyc();
        idat = 32'h0C0B0A09; cyc();
        ival = 1'b0;
        idle(8);
        exp_q.push_back(24'h030201); exp_q.push_back(24'h060504);
        exp_q.push_back(24'h090807); exp_q.push_back(24'h0C0B0A);
        cmp_pix("n3_burst");
        chk("n3_burst_fill", 32'(o_fill), 32'h0);

        // N=1, single word splits into four pixels
        i_num_channel = 2'd1;
        send(32'hDDCCBBAA);
        idle(8);
        exp_q.push_back(24'h0000AA); exp_q.push_back(24'h0000BB);
        exp_q.push_back(24'h0000CC); exp_q.push_back(24'h0000DD);
        cmp_pix("n1_split");

        // N=3, two words then end-of-frame flush
        i_num_channel = 2'd3;
        ival = 1'b1;
        idat = 32'h04030201; cyc();
        idat = 32'h08070605; cyc();
        ival = 1'b0;
        idle(4);
        chk("flush_residual_fill", 32'(o_fill), 32'h2);
        flush_pulse();
        idle(4);
        exp_q.push_back(24'h030201); exp_q.push_back(24'h060504); exp_q.push_back(24'h000807);
        cmp_pix("n3_flush");
        chk("n3_flush_fill", 32'(o_fill), 32'h0);

        // Backpressure with a compliant upstream
        ordy = 1'b0; nw = 0; saw_stall = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!ostall) begin
                ival = 1'b1;
                idat = {b(4*nw+4), b(4*nw+3), b(4*nw+2), b(4*nw+1)};
                nw++;
            end else begin
                ival = 1'b0;
            end
            cyc();
            if (ostall) saw_stall = 1'b1;
        end
        ival = 1'b0;
        chk("bp_odat_stable", 32'(odat), 32'h030201);
        chk("bp_oval", 32'(oval), 32'h1);
        chk("bp_saw_stall", 32'(saw_stall), 32'h1);
        chk("bp_no_ovf", 32'(o_err_ovf), 32'h0);
        ordy = 1'b1;
        idle(14);
        flush_pulse();
        idle(4);
        for (int i = 0; i < (4*nw)/3; i++) exp_q.push_back({b(3*i+3), b(3*i+2), b(3*i+1)});
        if ((4*nw) % 3 == 2) exp_q.push_back({8'h00, b(4*nw), b(4*nw-1)});
        if ((4*nw) % 3 == 1) exp_q.push_back({8'h00, 8'h00, b(4*nw)});
        cmp_pix("bp_order");
        chk("bp_fill", 32'(o_fill), 32'h0);

        // Upstream ignores ostall with the consumer blocked
        ordy = 1'b0;
        ival = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idat = 32'h11111111 * (k + 1);
            cyc();
        end
        ival = 1'b0;
        chk("ovf_set", 32'(o_err_ovf), 32'h1);
        chk("ovf_fill", 32'(o_fill), 32'd13);
        idle(3);
        chk("ovf_sticky", 32'(o_err_ovf), 32'h1);
        i_clear = 1'b1; ival = 1'b1; idat = 32'hDEADBEEF;
        cyc();
        i_clear = 1'b0; ival = 1'b0;
        chk("clear_fill", 32'(o_fill), 32'h0);
        chk("clear_oval", 32'(oval), 32'h0);
        chk("clear_err", 32'(o_err_ovf), 32'h0);
        got_q.delete();

        // Reset mid-stream with a pixel pending and seven samples buffered
        i_num_channel = 2'd1;
        ival = 1'b1;
        idat = 32'h44332211; cyc();
        idat = 32'h88776655; cyc();
        ival = 1'b0;
        chk("pre_rst_fill", 32'(o_fill), 32'd7);
        chk("pre_rst_oval", 32'(oval), 32'h1);
        rst = 1'b0;
        cyc();
        chk("rst_oval", 32'(oval), 32'h0);
        chk("rst_odat", 32'(odat), 32'h0);
        chk("rst_fill", 32'(o_fill), 32'h0);
        chk("rst_ostall", 32'(ostall), 32'h0);
        chk("rst_err", 32'(o_err_ovf), 32'h0);
        rst = 1'b1; i_num_channel = 2'd3; ordy = 1'b1;
        got_q.delete();
        send(32'h04030201);
        idle(3);
        exp_q.push_back(24'h030201);
        cmp_pix("post_rst");
        flush_pulse();
        idle(3);
        got_q.delete();

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if (m_q.size() == 0 && !m_oval && $urandom_range(0, 19) == 0)
                i_num_channel = 2'($urandom_range(0, 3));
            ordy    = ($urandom_range(0, 3) != 0);
            w       = $urandom();
            idat    = w;
            ival    = !ostall && ($urandom_range(0, 2) != 0);
            i_flush = ($urandom_range(0, 29) == 0);
            i_clear = ($urandom_range(0, 299) == 0);
            cyc();
        end
        ival = 1'b0; i_flush = 1'b0; i_clear = 1'b0; ordy = 1'b1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pixel_repacker.md
# pixel_repacker

Parametrised successor to the input-side pixel concatenator. It sits between the data-BRAM `bram_ctrl` read port and `accelerator_core` `i_data`/`i_data_val`, and repacks a stream of `DATA_WIDTH` memory words into pixels of a runtime-selectable channel count. It adds a ready/valid output with backpressure, a stall margin sized to the upstream read latency, end-of-frame flush and overflow detection.

## Interface
- `BIT_WIDTH`, 8, bits per channel sample
- `NUM_CHANNEL`, 3, maximum channels per pixel; output width
- `DATA_WIDTH`, 32, memory word width; must be a multiple of `BIT_WIDTH`
- `BUF_BYTES`, 16, byte-buffer capacity in samples; must be ≥ 2·`DATA_WIDTH`/`BIT_WIDTH`
- `STALL_LAT`, 2, words that can still arrive after `ostall` rises (`data_req` + `bram_ctrl` latency)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `i_num_channel`  in  clog2(`NUM_CHANNEL`+1)  active channels per pixel; 0 or >`NUM_CHANNEL` is treated as `NUM_CHANNEL`
- `i_clear`  in  1  synchronous flush of all state, including the error flag
- `i_flush`  in  1  end-of-frame: emit the residual partial pixel, zero-padded
- `idat`  in  `DATA_WIDTH`  memory word; sample 0 = `idat[BIT_WIDTH-1:0]`
- `ival`  in  1  `idat` valid
- `ostall`  out  1  registered; upstream must stop issuing reads
- `odat`  out  `BIT_WIDTH*NUM_CHANNEL`  pixel; channel c = `odat[c*BIT_WIDTH +: BIT_WIDTH]`
- `oval`  out  1  `odat` valid
- `ordy`  in  1  consumer accepts `odat` when `oval & ordy`
- `o_fill`  out  clog2(`BUF_BYTES`+1)  buffered sample count
- `o_err_ovf`  out  1  sticky overflow flag

## Operation
- Let `W = DATA_WIDTH/BIT_WIDTH` and `N =` effective `i_num_channel`.
- **Buffer.** FIFO of `BUF_BYTES` samples.
  - Push `W` samples when `ival` and free ≥ `W`.
  - If `ival` and free < `W`: drop the whole word and set `o_err_ovf`.
- **Output register.** Holds one pixel.
  - Loads when `fcnt ≥ N` and (`!oval | ordy`).
  - Consumes the `N` oldest samples; the oldest goes to channel 0.
  - Channels ≥ `N` are zero.
- **Flush.** `i_flush` with `0 < fcnt < N`: at the next load opportunity, emit one pixel holding the residual samples and zero-padded remainder. `fcnt` then becomes 0.
- **Push and pop in the same cycle** are both legal; `fcnt_next = fcnt + pushed − popped`.
- **ostall.** Registered, equal to `fcnt_next > BUF_BYTES − W·(STALL_LAT+1)`. This guarantees no overflow for a compliant upstream.
- **Pending-accept FSM.** States IDLE (`!oval`) and HOLD (`oval`).
  - IDLE → HOLD on load.
  - HOLD → IDLE on `ordy` with no reload.
  - HOLD → HOLD on `ordy` with reload, or on `!ordy`.
  - `odat` is stable while `oval & !ordy`.
- **Precedence.** `rst` > `i_clear` > normal operation.
  - `i_clear` empties the buffer, drops `oval`, clears `o_err_ovf`, and drops any `ival` word in the same cycle.
- **`i_num_channel` changes** are only legal when `fcnt == 0` and `!oval`. Otherwise behaviour is undefined, though the block must not lock up.

## Timing
- Reset (`rst=0` at an edge) forces: `oval=0`, `odat=0`, `ostall=0`, `o_fill=0`, `o_err_ovf=0`, FSM=IDLE.
- Latency: `ival` in cycle n with an empty buffer and `N ≤ W` → earliest `oval` in cycle n+1 (push at edge n, load at edge n+1, visible at n+1 after that edge). Summary: word captured at edge e, pixel visible after edge e+1.
- Throughput: one pixel per cycle while `fcnt ≥ N` and `ordy=1`.
- `ostall` reflects the state one edge after the push or pop that caused it.
- `o_fill` is registered and equals `fcnt`.
- `o_err_ovf` rises at the edge after the dropped word.

## Structure
- Shared package `accel_pkg` holds:
  - `clog2` function
  - `W` derivation
  - parameter legality checks (`DATA_WIDTH % BIT_WIDTH`, `BUF_BYTES ≥ 2W`)
- Sub-module `sample_fifo`: circular sample buffer with variable push count (`W`) and pop count (`N`, 0..`NUM_CHANNEL`).
  - Ports: `rd_ptr`, `wr_ptr`, `fcnt`.
  - Wrap-around is modulo `BUF_BYTES`; `BUF_BYTES` need not be a power of 2.
- Top level holds the output register, FSM, stall logic and error flag.

## Test plan
- **N=3, continuous 3 words** `0x04030201, 0x08070605, 0x0C0B0A09`, `ordy=1` → 4 pixels `0x030201, 0x060504, 0x090807, 0x0C0B0A`; final `o_fill=0`.
- **N=1, one word** `0xDDCCBBAA` → 4 pixels `0x0000AA, 0x0000BB, 0x0000CC, 0x0000DD` on consecutive cycles.
- **N=3, 2 words then `i_flush`** → pixels `0x030201, 0x060504`, then a flushed pixel `0x000807`; `o_fill=0`.
- **N=3, `ordy` held low 10 cycles while pushing** → `odat` stable at `0x030201`; `ostall` rises when `fcnt > 4` (default params); no overflow; all pixels in order after release.
- **Upstream ignores `ostall`, `ordy=0`, `ival` every cycle** → 5th word dropped; `o_err_ovf=1` and stays set until `i_clear`, after which `o_fill=0` and `oval=0`.
- **`rst=0` mid-stream with `oval=1`, `o_fill=7`** → at the next edge all outputs hold their reset values; the first word after release produces `0x030201` again.
